led_scan_display: RTL and testbench

Eight-digit multiplexed seven-segment driver that reads the CPU's display/statistics outputs (`Leddata`, `Count_all`, `Count_branch`, `Count_jmp`) and scans one selected 32-bit word as 8 hex digits. It sits between the pipeline CPU top level and the board's common-anode display pins. The selected word is captured once per full scan frame, so a digit sequence never mixes two values.

---
 rtl/led_scan_if.sv | 23 ++
 rtl/led_scan_display.sv | 106 ++++++++++
 tb/tb_led_scan_display.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/led_scan_if.sv
// Signal bundle between the CPU's display/statistics outputs and the seven-segment scanner.
// The master side provides the words and the source select; the slave side drives the display pins.
interface led_scan_if;
    logic [31:0] Leddata;
    logic [31:0] Count_all;
    logic [31:0] Count_branch;
    logic [31:0] Count_jmp;
    logic [1:0]  sel;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame;

    modport master (
        output Leddata, Count_all, Count_branch, Count_jmp, sel,
        input  an, seg, dp, frame
    );

    modport slave (
        input  Leddata, Count_all, Count_branch, Count_jmp, sel,
        output an, seg, dp, frame
    );
endinterface

// File: rtl/led_scan_display.sv
// Eight-digit multiplexed common-anode hex display driver.
// The selected word is latched once per scan frame, so one sweep never mixes two values.
module led_scan_display #(
    parameter int SCAN_DIV = 100000,
    parameter bit BLANK_LZ = 1'b0
) (
    input  logic       clk,
    input  logic       clr,
    led_scan_if.slave  bus
);

    localparam int PW = $clog2((SCAN_DIV < 2) ? 2 : SCAN_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

    logic [PW-1:0] presc;
    logic          tick;
    logic [2:0]    idx;
    logic [2:0]    idx_nxt;
    logic          capture;
    logic [31:0]   shadow;
    logic [31:0]   shadow_nxt;
    logic [31:0]   word_sel;
    logic [1:0]    sel_q;
    logic [1:0]    sel_nxt;
    logic [3:0]    nibble;
    logic          blank;
    logic [7:0]    an_nxt;
    logic [6:0]    seg_nxt;
    logic          dp_nxt;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // True when every nibble from digit n upward is zero.
    function automatic logic upper_zero(input logic [31:0] w, input logic [2:0] n);
        return (w >> {n, 2'b00}) == 32'd0;
    endfunction

    always_comb begin
        tick    = (presc == PRESC_LAST);
        idx_nxt = idx + 3'd1;
        capture = tick && (idx == 3'd7);

        case (bus.sel)
            2'd0:    word_sel = bus.Leddata;
            2'd1:    word_sel = bus.Count_all;
            2'd2:    word_sel = bus.Count_branch;
            default: word_sel = bus.Count_jmp;
        endcase

        // Digit 0 must show the word captured on this same edge.
        shadow_nxt = capture ? word_sel : shadow;
        sel_nxt    = capture ? bus.sel  : sel_q;

        nibble  = shadow_nxt[{idx_nxt, 2'b00} +: 4];
        blank   = BLANK_LZ && (idx_nxt != 3'd0) && upper_zero(shadow_nxt, idx_nxt);
        an_nxt  = ~(8'h01 << idx_nxt);
        seg_nxt = blank ? 7'h7F : hex_to_seg(nibble);
        dp_nxt  = !((idx_nxt == 3'd0) && (sel_nxt != 2'd0));
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            presc     <= '0;
            idx       <= 3'd7;
            shadow    <= 32'd0;
            sel_q     <= 2'd0;
            bus.an    <= 8'hFF;
            bus.seg   <= 7'h7F;
            bus.dp    <= 1'b1;
            bus.frame <= 1'b0;
        end else begin
            presc     <= tick ? '0 : presc + 1'b1;
            bus.frame <= capture;
            if (tick) begin
                idx     <= idx_nxt;
                shadow  <= shadow_nxt;
                sel_q   <= sel_nxt;
                bus.an  <= an_nxt;
                bus.seg <= seg_nxt;
                bus.dp  <= dp_nxt;
            end
        end
    end

endmodule

// File: tb/tb_led_scan_display.sv
// Scoreboard bench for led_scan_display: three instances (div 2, div 2 with blanking, div 1)
// share one set of inputs; whole expected frames are queued at each capture edge.
module tb_led_scan_display;

    localparam logic [6:0] SEG_TAB [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    localparam logic [16:0] RST_OBS = {1'b0, 1'b1, 7'h7F, 8'hFF};
    localparam int DIV [3] = '{2, 2, 1};
    localparam bit BLK [3] = '{1'b0, 1'b1, 1'b0};

    logic clk = 1'b0;
    logic clr = 1'b0;
    logic [31:0] led, cnt_all, cnt_br, cnt_jmp;
    logic [1:0]  sel;
    int   cyc = 0;
    bit   mon_en = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    logic [16:0] qa[$];
    logic [16:0] qb[$];
    logic [16:0] qc[$];

    always #5 clk = ~clk;

    led_scan_if ifa ();
    led_scan_if ifb ();
    led_scan_if ifc ();

    assign ifa.Leddata = led;  assign ifa.Count_all = cnt_all;
    assign ifa.Count_branch = cnt_br;  assign ifa.Count_jmp = cnt_jmp;  assign ifa.sel = sel;
    assign ifb.Leddata = led;  assign ifb.Count_all = cnt_all;
    assign ifb.Count_branch = cnt_br;  assign ifb.Count_jmp = cnt_jmp;  assign ifb.sel = sel;
    assign ifc.Leddata = led;  assign ifc.Count_all = cnt_all;
    assign ifc.Count_branch = cnt_br;  assign ifc.Count_jmp = cnt_jmp;  assign ifc.sel = sel;

    led_scan_display #(.SCAN_DIV(2), .BLANK_LZ(1'b0)) dut_a (.clk(clk), .clr(clr), .bus(ifa));
    led_scan_display #(.SCAN_DIV(2), .BLANK_LZ(1'b1)) dut_b (.clk(clk), .clr(clr), .bus(ifb));
    led_scan_display #(.SCAN_DIV(1), .BLANK_LZ(1'b0)) dut_c (.clk(clk), .clr(clr), .bus(ifc));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected {frame, dp, seg, an} for sample i of a frame showing word w.
    function automatic logic [16:0] model(int d, bit bl, logic [31:0] w, logic [1:0] s, int i);
        int j;
        logic [7:0] an;
        logic [6:0] sg;
        logic [3:0] nib;
        logic dp;
        j = i / d;
        an = 8'hFF;
        an[j] = 1'b0;
        nib = w[4*j +: 4];
        sg = SEG_TAB[nib];
        if (bl && j > 0 && (w >> (4*j)) == 32'd0) sg = 7'h7F;
        dp = (j == 0 && s != 2'd0) ? 1'b0 : 1'b1;
        return {(i == 0), dp, sg, an};
    endfunction

    task automatic push(input int k, input logic [16:0] e);
        case (k)
            0: qa.push_back(e);
            1: qb.push_back(e);
            default: qc.push_back(e);
        endcase
    endtask

    task automatic push_frame(input int k);
        logic [31:0] w;
        case (sel)
            2'd0: w = led;
            2'd1: w = cnt_all;
            2'd2: w = cnt_br;
            default: w = cnt_jmp;
        endcase
        for (int i = 0; i < 8 * DIV[k]; i++) push(k, model(DIV[k], BLK[k], w, sel, i));
    endtask

    task automatic push_idle();
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < DIV[k] - 1; i++) push(k, RST_OBS);
    endtask

    // Called at a negedge; queues a frame for every instance whose next edge captures.
    task automatic step();
        for (int k = 0; k < 3; k++)
            if (cyc >= DIV[k] - 1 && ((cyc - (DIV[k] - 1)) % (8 * DIV[k])) == 0) push_frame(k);
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic observe(input int k, input logic [16:0] obs);
        logic [16:0] e;
        string tag;
        int sz;
        tag = $sformatf("dut%0d_cyc%0d", k, cyc);
        case (k)
            0: sz = qa.size();
            1: sz = qb.size();
            default: sz = qc.size();
        endcase
        if (sz == 0) begin
            check({tag, "_queue_empty"}, sz, 1);
        end else begin
            case (k)
                0: e = qa.pop_front();
                1: e = qb.pop_front();
                default: e = qc.pop_front();
            endcase
            check(tag, obs, e);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            observe(0, {ifa.frame, ifa.dp, ifa.seg, ifa.an});
            observe(1, {ifb.frame, ifb.dp, ifb.seg, ifb.an});
            observe(2, {ifc.frame, ifc.dp, ifc.seg, ifc.an});
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_a"}, {ifa.frame, ifa.dp, ifa.seg, ifa.an}, RST_OBS);
        check({tag, "_b"}, {ifb.frame, ifb.dp, ifb.seg, ifb.an}, RST_OBS);
        check({tag, "_c"}, {ifc.frame, ifc.dp, ifc.seg, ifc.an}, RST_OBS);
    endtask

    task automatic release_reset();
        clr = 1'b1;
        cyc = 0;
        push_idle();
        mon_en = 1'b1;
    endtask

    initial begin
        led = 32'h1234ABCD;
        cnt_all = 32'hFFFFFFFF;
        cnt_br = 32'h00000005;
        cnt_jmp = 32'h9876F0E1;
        sel = 2'd0;
        repeat (3) @(negedge clk);
        check_reset_outputs("power_on_reset");
        release_reset();

        // Leddata frames; switch to Count_jmp while dut_a shows digit 3.
        run_to(40);
        sel = 2'd3;
        run_to(72);
        // Count_branch with a single significant digit.
        sel = 2'd2;
        run_to(110);
        // All-ones counter.
        sel = 2'd1;
        run_to(150);
        // Zero word.
        sel = 2'd0;
        led = 32'h0;
        run_to(190);

        // Stop just after dut_a starts showing digit 5, then reset between edges.
        while (((cyc - 2) % 16) != 10) step();
        check("idx5_an_before_reset", {24'h0, ifa.an}, 32'h000000DF);
        mon_en = 1'b0;
        #2;
        clr = 1'b0;
        #1;
        check_reset_outputs("async_reset_midframe");
        qa.delete();
        qb.delete();
        qc.delete();
        @(posedge clk);
        #1;
        check_reset_outputs("reset_held_edge");
        @(negedge clk);
        led = 32'h1234ABCD;
        sel = 2'd0;
        release_reset();
        run_to(40);

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got %0d cycles expected completion", cyc);
        $fatal(1, "timeout");
    end

endmodule
